// File: rtl/move_stepper_ctrl_pkg.sv
// Shared definitions for the cube-robot face stepper controller.
//   state_t          : sequencing FSM state encoding
//   FACE_* / INV_BIT : move_code field layout (face index stored +1, bit 0 = inverse)
//   max3()           : helper for sizing the shared cycle timer
package rbot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STEP_HI,
        S_STEP_LO,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam int CODE_W    = 4;
    localparam int FACE_LSB  = 1;
    localparam int FACE_MSB  = 3;
    localparam int FACE_BASE = 1;
    localparam int INV_BIT   = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/move_stepper_ctrl_if.sv
// Move request / completion handshake between the sequencer host and the
// stepper controller.
//   move_code  : [3:1] face index + 1, [0] inverse (counter-clockwise)
//   half_turn  : 1 = 180 degree move
//   move_valid : request, accepted when move_valid & move_ready
//   move_ready : controller idle
//   move_done  : one-cycle completion pulse
//   move_err   : one-cycle pulse after an invalid code was accepted
interface move_stepper_ctrl_if;
    logic [3:0] move_code;
    logic       half_turn;
    logic       move_valid;
    logic       move_ready;
    logic       move_done;
    logic       move_err;

    modport master (
        output move_code, half_turn, move_valid,
        input  move_ready, move_done, move_err
    );

    modport slave (
        input  move_code, half_turn, move_valid,
        output move_ready, move_done, move_err
    );
endinterface

// File: rtl/move_stepper_ctrl_step_timer.sv
// Loadable down-counter with terminal-count flag. Loading N-1 makes the
// owner state last exactly N cycles; the count holds at zero (never wraps).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : load load_val this cycle (overrides decrement)
//   load_val     : reload value
//   tc           : count is zero
module step_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/move_stepper_ctrl.sv
// Face stepper move controller: accepts one move at a time, enables the
// selected face driver, sets direction, emits a burst of step pulses on the
// shared step line, settles, then reports completion.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   mv           : move request handshake (slave side)
//   dir_pin      : !inverse of the accepted move, held through the move
//   step_pin     : shared step pulse
//   en_pins      : one-hot enable of the selected face driver
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | ready for a move, all drivers disabled
// S_SETUP   | driver enabled, direction settling before 1st step
// S_STEP_HI | step line high for one half period
// S_STEP_LO | step line low for one half period
// S_SETTLE  | all steps issued, driver held enabled while rotor settles
// S_DONE    | single-cycle completion pulse, driver disabled
module move_stepper_ctrl
    import rbot_pkg::*;
#(
    parameter int NUM_FACES        = 6,
    parameter int QUARTER_STEPS    = 51,
    parameter int STEP_HALF_PERIOD = 62500,
    parameter int DIR_SETUP        = 10,
    parameter int SETTLE_CYCLES    = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    move_stepper_ctrl_if.slave   mv,
    output logic                 dir_pin,
    output logic                 step_pin,
    output logic [NUM_FACES-1:0] en_pins
);
    localparam int CNT_W  = $clog2(max3(STEP_HALF_PERIOD, DIR_SETUP, SETTLE_CYCLES) + 1);
    localparam int STEP_W = $clog2(2 * QUARTER_STEPS + 1);

    localparam logic [2:0]       FACE_ONE   = 3'(FACE_BASE);
    localparam logic [2:0]       FACE_LAST  = 3'(NUM_FACES);
    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PHASE   = CNT_W'(STEP_HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [NUM_FACES-1:0] EN_LSB = NUM_FACES'(1);

    state_t            state, state_next;
    logic [2:0]        face_field;
    logic [2:0]        face_q;
    logic              half_q;
    logic              err_q;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] steps_target;
    logic              accept;
    logic              code_ok;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_tc;

    assign face_field   = mv.move_code[FACE_MSB:FACE_LSB];
    assign code_ok      = (face_field >= FACE_ONE) && (face_field <= FACE_LAST);
    assign accept       = mv.move_valid && (state == S_IDLE);
    assign steps_target = half_q ? STEP_W'(2 * QUARTER_STEPS) : STEP_W'(QUARTER_STEPS);

    step_timer #(.WIDTH(CNT_W)) u_step_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timer is reloaded on every state change with the length of the state entered.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state)
            S_IDLE: begin
                if (accept && code_ok) begin
                    state_next = S_SETUP;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_SETUP;
                end
            end
            S_SETUP: begin
                if (tmr_tc) begin
                    state_next = S_STEP_HI;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_PHASE;
                end
            end
            S_STEP_HI: begin
                if (tmr_tc) begin
                    state_next = S_STEP_LO;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_PHASE;
                end
            end
            S_STEP_LO: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (steps_q == steps_target) begin
                        state_next = S_SETTLE;
                        tmr_val    = LD_SETTLE;
                    end else begin
                        state_next = S_STEP_HI;
                        tmr_val    = LD_PHASE;
                    end
                end
            end
            S_SETTLE: begin
                if (tmr_tc) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mv.move_ready = 1'b0;
        mv.move_done  = 1'b0;
        step_pin      = 1'b0;
        en_pins       = '0;
        case (state)
            S_IDLE:    mv.move_ready = 1'b1;
            S_SETUP:   en_pins = EN_LSB << face_q;
            S_STEP_HI: begin
                en_pins  = EN_LSB << face_q;
                step_pin = 1'b1;
            end
            S_STEP_LO: en_pins = EN_LSB << face_q;
            S_SETTLE:  en_pins = EN_LSB << face_q;
            S_DONE:    mv.move_done = 1'b1;
            default:   ;
        endcase
    end

    assign mv.move_err = err_q;

    // Step edges are counted when STEP_HI is entered, so the count equals the
    // number of pulses already issued while in STEP_LO.
    always_ff @(posedge clock) begin
        if (reset) begin
            face_q  <= '0;
            half_q  <= 1'b0;
            dir_pin <= 1'b0;
            err_q   <= 1'b0;
            steps_q <= '0;
        end else begin
            err_q <= accept && !code_ok;
            if (accept && code_ok) begin
                face_q  <= face_field - FACE_ONE;
                half_q  <= mv.half_turn;
                dir_pin <= !mv.move_code[INV_BIT];
                steps_q <= '0;
            end else if (state_next == S_STEP_HI && state != S_STEP_HI) begin
                steps_q <= steps_q + 1'b1;
            end
        end
    end
endmodule
